store_monitor: RTL and testbench

//   Observes the computer's data-memory store bus (memWrite/dataAddr/writeData), logs

---
 rtl/store_monitor.sv | 112 +++++++++++
 tb/tb_store_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// Store-bus monitor: logs every store into a FIFO for host readout and flags completion.
// Optional run timeout that forces FAIL is enabled by defining STORE_MON_TIMEOUT_EN.
module store_monitor #(
    parameter int              n         = 32,
    parameter int              DEPTH     = 8,
    parameter logic [n-1:0]    PASS_ADDR = 84,
    parameter logic [n-1:0]    PASS_DATA = 32'h96,
    parameter int              TIMEOUT   = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memWrite,
    input  logic [n-1:0]             dataAddr,
    input  logic [n-1:0]             writeData,
    input  logic                     pop,
    output logic                     logValid,
    output logic [n-1:0]             logAddr,
    output logic [n-1:0]             logData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass,
    output logic                     fail
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [2*n-1:0]  mem [DEPTH];

    logic in_run;
    logic match;
    logic timeout;
    logic do_pop;
    logic do_push;
    logic full;

    assign in_run   = (state == RUN);
    assign match    = memWrite && (dataAddr == PASS_ADDR) && (writeData == PASS_DATA);
    assign full     = (count == CW'(DEPTH));
    assign logValid = (count != '0);
    assign do_pop   = pop && logValid;
    // A full FIFO still accepts a store when the head is consumed in the same cycle.
    assign do_push  = memWrite && in_run && (!full || do_pop);

    assign logAddr  = mem[rd_ptr][2*n-1:n];
    assign logData  = mem[rd_ptr][n-1:0];

    // Storage carries no reset; visibility is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {dataAddr, writeData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            if (memWrite && in_run && !do_push) overflow <= 1'b1;
        end
    end

`ifdef STORE_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else if (in_run) begin
            cycles <= cycles + TW'(1);
        end
    end

    assign timeout = in_run && (cycles == TW'(TIMEOUT - 1));
    assign fail    = (state == FAIL);
`else
    // No run timer in this build; FAIL can never be entered.
    assign timeout = 1'b0 && (TIMEOUT == 0);
    assign fail    = 1'b0;
`endif

    // Completion FSM; a match on the timeout cycle resolves to PASS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (match)        state <= PASS;
                    else if (timeout) state <= FAIL;
                end
                default: state <= state;
            endcase
        end
    end

    assign done = (state != RUN);
    assign pass = (state == PASS);
endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: FIFO logging, overflow, completion FSM and timeout.
`timescale 1ns/1ps
module tb_store_monitor;
    localparam int N = 32;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          memWrite = 1'b0;
    logic [N-1:0]  dataAddr = '0;
    logic [N-1:0]  writeData = '0;
    logic          pop = 1'b0;
    logic          logValid;
    logic [N-1:0]  logAddr;
    logic [N-1:0]  logData;
    logic [3:0]    count;
    logic          overflow;
    logic          done;
    logic          pass;
    logic          fail;

    int checks = 0;
    int failures = 0;

    store_monitor #(
        .n(N), .DEPTH(D), .PASS_ADDR(84), .PASS_DATA(32'h96), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .memWrite(memWrite), .dataAddr(dataAddr),
        .writeData(writeData), .pop(pop), .logValid(logValid), .logAddr(logAddr),
        .logData(logData), .count(count), .overflow(overflow), .done(done),
        .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; memWrite = 1'b0; pop = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
        memWrite = 1'b1; dataAddr = a; writeData = d;
        tick();
        memWrite = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (logValid !== 1'b0) begin failures++; $display("FAIL reset_logValid got=%b exp=0", logValid); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if ({done, pass, fail} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, pass, fail}); end
    endtask

    task automatic test_single();
        do_reset();
        store(32'h10, 32'hDEADBEEF);
        checks++; if (logValid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", logValid); end
        checks++; if (logAddr !== 32'h10) begin failures++; $display("FAIL single_addr got=%h exp=10", logAddr); end
        checks++; if (logData !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", logData); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        do_pop();
        checks++; if (logValid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL single_pop got valid=%b count=%0d exp valid=0 count=0", logValid, count); end
        do_pop();
        checks++; if (count !== 4'd0 || overflow !== 1'b0) begin failures++; $display("FAIL empty_pop got count=%0d ovf=%b exp 0/0", count, overflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i <= 8; i++) store(32'(4 * i), 32'(i));
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (logValid !== 1'b1 || logAddr !== 32'(4 * i) || logData !== 32'(i)) begin
                failures++;
                $display("FAIL ovf_order[%0d] got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, logValid, logAddr, logData, 4 * i, i);
            end
            do_pop();
        end
        checks++; if (logValid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", logValid); end
        store(32'h44, 32'h55);
        do_reset();
        checks++; if (count !== 4'd0 || overflow !== 1'b0 || logValid !== 1'b0) begin failures++; $display("FAIL ovf_reset got c=%0d o=%b v=%b exp 0/0/0", count, overflow, logValid); end
    endtask

    task automatic test_pass();
        do_reset();
        store(32'd84, 32'h96);
        checks++; if ({done, pass, fail} !== 3'b110) begin failures++; $display("FAIL pass_flags got=%b exp=110", {done, pass, fail}); end
        checks++; if (count !== 4'd1 || logAddr !== 32'd84 || logData !== 32'h96) begin failures++; $display("FAIL pass_logged got c=%0d a=%h d=%h exp 1/54/96", count, logAddr, logData); end
        store(32'h20, 32'h1);
        checks++; if (count !== 4'd1 || overflow !== 1'b0) begin failures++; $display("FAIL pass_ignored got c=%0d o=%b exp 1/0", count, overflow); end
        do_pop();
        checks++; if (count !== 4'd0 || pass !== 1'b1) begin failures++; $display("FAIL pass_pop got c=%0d pass=%b exp 0/1", count, pass); end
    endtask

    task automatic test_near_miss();
        do_reset();
        store(32'd84, 32'h95);
        store(32'd88, 32'h96);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL miss_count got=%0d exp=2", count); end
        checks++; if (pass !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL miss_flags got pass=%b done=%b exp 0/0", pass, done); end
        checks++; if (logAddr !== 32'd84 || logData !== 32'h95) begin failures++; $display("FAIL miss_head got a=%h d=%h exp 54/95", logAddr, logData); end
        do_pop();
        checks++; if (logAddr !== 32'd88 || logData !== 32'h96) begin failures++; $display("FAIL miss_second got a=%h d=%h exp 58/96", logAddr, logData); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        memWrite = 1'b1; pop = 1'b1; dataAddr = 32'h300; writeData = 32'h77;
        tick();
        memWrite = 1'b0; pop = 1'b0;
        checks++; if (count !== 4'd1 || logData !== 32'h77) begin failures++; $display("FAIL empty_pushpop got c=%0d d=%h exp 1/77", count, logData); end
        do_reset();
        for (int i = 0; i < 8; i++) store(32'h100 + 32'(i), 32'h1000 + 32'(i));
        memWrite = 1'b1; pop = 1'b1; dataAddr = 32'h200; writeData = 32'hABC;
        tick();
        memWrite = 1'b0; pop = 1'b0;
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL full_pushpop got c=%0d o=%b exp 8/0", count, overflow); end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (logData !== 32'h1000 + 32'(i)) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", i, logData, 32'h1000 + i); end
            do_pop();
        end
        checks++; if (logAddr !== 32'h200 || logData !== 32'hABC || count !== 4'd1) begin failures++; $display("FAIL full_last got a=%h d=%h c=%0d exp 200/abc/1", logAddr, logData, count); end
    endtask

    task automatic test_timeout();
`ifdef STORE_MON_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (fail !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL to_early got fail=%b done=%b exp 0/0", fail, done); end
        tick();
        checks++; if (fail !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL to_fire got f=%b d=%b p=%b exp 1/1/0", fail, done, pass); end
        store(32'd84, 32'h96);
        checks++; if (pass !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL to_terminal got p=%b c=%0d exp 0/0", pass, count); end
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        store(32'd84, 32'h96);
        checks++; if (pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL to_pass_wins got p=%b f=%b exp 1/0", pass, fail); end
`else
        do_reset();
        for (int i = 0; i < 100; i++) tick();
        checks++; if (fail !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL no_timeout got fail=%b done=%b exp 0/0", fail, done); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_pass();
        test_near_miss();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
